// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Brief    : Recovers DE/x/y from HS/VS/blank, measures timing, locks on stability
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
   parameter int LOCK_FRAMES = 2,
   parameter int H_ACTIVE    = 640
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        blank_n_in,
   output logic        de,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic [10:0] h_total,
   output logic [9:0]  v_total,
   output logic [7:0]  hs_width,
   output logic        locked,
   output logic        error
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [10:0]     c_LC_MAX = 11'd2047;
   localparam logic [9:0]      c_FC_MAX = 10'd1023;
   localparam logic [9:0]      c_X_MAX  = 10'd1023;
   localparam logic [8:0]      c_Y_MAX  = 9'd511;
   localparam logic [7:0]      c_HL_MAX = 8'd255;
   localparam logic [10:0]     c_H_ACT  = 11'(H_ACTIVE);
   localparam int              c_MW     = $clog2(LOCK_FRAMES + 1);
   localparam logic [c_MW-1:0] c_LOCK   = c_MW'(LOCK_FRAMES);

   state_t          state_q;
   logic            s_hs_q, s_vs_q, s_bl_q, p_hs_q, p_vs_q;
   logic            de_q;
   logic [9:0]      x_q, x_d;
   logic [8:0]      y_q, y_d;
   logic [10:0]     lc_q, lc_d, h_total_q;
   logic [9:0]      fc_q, fc_d, v_total_q;
   logic [7:0]      hl_q, hl_d, hs_width_q;
   logic [c_MW-1:0] match_q;
   logic            line_bad_q, locked_q, error_q;

   logic            w_hs_fall, w_hs_rise, w_vs_fall, w_de_fall;
   logic [10:0]     w_line_len;
   logic            w_line_err, w_lc_sat, w_fc_sat, w_v_bad, w_frame_ok;
   logic [c_MW-1:0] w_match_inc;

   assign w_hs_fall   = p_hs_q & ~s_hs_q;
   assign w_hs_rise   = ~p_hs_q & s_hs_q;
   assign w_vs_fall   = p_vs_q & ~s_vs_q;
   assign w_de_fall   = de_q & ~s_bl_q;
   assign w_line_len  = (lc_q == c_LC_MAX) ? c_LC_MAX : lc_q + 11'd1;
   assign w_line_err  = (w_hs_fall && (w_line_len != h_total_q)) ||
                        (w_de_fall && (({1'b0, x_q} + 11'd1) != c_H_ACT));
   // Single-cycle saturation events: fire only on the step into the limit
   assign w_lc_sat    = !w_hs_fall && (lc_q == c_LC_MAX - 11'd1);
   assign w_fc_sat    = w_hs_fall && !w_vs_fall && (fc_q == c_FC_MAX - 10'd1);
   assign w_v_bad     = w_vs_fall && (fc_q != v_total_q);
   assign w_frame_ok  = !line_bad_q && !w_line_err && (fc_q == v_total_q);
   assign w_match_inc = match_q + c_MW'(1);

   always_comb begin
      lc_d = w_hs_fall ? 11'd0 : ((lc_q == c_LC_MAX) ? lc_q : lc_q + 11'd1);
      fc_d = fc_q;
      // A coincident HS edge is line 0 of the new frame
      if (w_vs_fall)
         fc_d = w_hs_fall ? 10'd1 : 10'd0;
      else if (w_hs_fall && fc_q != c_FC_MAX)
         fc_d = fc_q + 10'd1;
      hl_d = s_hs_q ? 8'd0 : ((hl_q == c_HL_MAX) ? hl_q : hl_q + 8'd1);
      x_d  = (s_bl_q && de_q) ? ((x_q == c_X_MAX) ? x_q : x_q + 10'd1) : 10'd0;
      y_d  = y_q;
      if (w_vs_fall)
         y_d = 9'd0;
      else if (w_de_fall && y_q != c_Y_MAX)
         y_d = y_q + 9'd1;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         s_hs_q     <= 1'b1;
         s_vs_q     <= 1'b1;
         s_bl_q     <= 1'b0;
         p_hs_q     <= 1'b1;
         p_vs_q     <= 1'b1;
         de_q       <= 1'b0;
         x_q        <= 10'd0;
         y_q        <= 9'd0;
         lc_q       <= 11'd0;
         fc_q       <= 10'd0;
         hl_q       <= 8'd0;
         h_total_q  <= 11'd0;
         hs_width_q <= 8'd0;
      end else begin
         s_hs_q <= hs_in;
         s_vs_q <= vs_in;
         s_bl_q <= blank_n_in;
         p_hs_q <= s_hs_q;
         p_vs_q <= s_vs_q;
         de_q   <= s_bl_q;
         x_q    <= x_d;
         y_q    <= y_d;
         lc_q   <= lc_d;
         fc_q   <= fc_d;
         hl_q   <= hl_d;
         if (w_hs_fall) h_total_q  <= w_line_len;
         if (w_hs_rise) hs_width_q <= hl_q;
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state_q    <= SEARCH;
         match_q    <= '0;
         line_bad_q <= 1'b0;
         v_total_q  <= 10'd0;
         locked_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         error_q <= 1'b0;
         if (w_line_err) line_bad_q <= 1'b1;
         case (state_q)
            SEARCH: begin
               if (w_vs_fall) begin
                  state_q    <= MEASURE;
                  line_bad_q <= 1'b0;
                  match_q    <= '0;
               end
            end
            MEASURE: begin
               if (w_vs_fall) begin
                  v_total_q  <= fc_q;
                  line_bad_q <= 1'b0;
                  if (!w_frame_ok) begin
                     match_q <= '0;
                  end else begin
                     match_q <= w_match_inc;
                     if (w_match_inc == c_LOCK) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end
               end
               if (w_lc_sat || w_fc_sat) match_q <= '0;
            end
            LOCKED: begin
               if (w_vs_fall) begin
                  v_total_q  <= fc_q;
                  line_bad_q <= 1'b0;
               end
               if (w_line_err || w_v_bad || w_lc_sat || w_fc_sat) begin
                  error_q  <= 1'b1;
                  locked_q <= 1'b0;
                  match_q  <= '0;
                  state_q  <= SEARCH;
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

   assign de       = de_q;
   assign x        = x_q;
   assign y        = de_q ? y_q : 9'd0;
   assign h_total  = h_total_q;
   assign v_total  = v_total_q;
   assign hs_width = hs_width_q;
   assign locked   = locked_q;
   assign error    = error_q;

endmodule
`default_nettype wire
